// File: rtl/rs_gf_pkg.sv
// GF(256) field constants, polynomial types and helpers shared by the RS key-equation stage.
// Pure combinational helpers; no state, no flow control.
package rs_gf_pkg;
  localparam int         GF_W      = 8;
  localparam logic [8:0] GF_POLY   = 9'h11D;
  localparam int         RS_T      = 2;
  localparam int         RS_NSYND  = 4;

  typedef logic [GF_W-1:0]       gf_elem_t;
  typedef gf_elem_t [RS_NSYND:0] poly_t;
  typedef logic signed [3:0]     deg_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DIV,
    ST_SWAP,
    ST_DONE
  } euc_state_t;

  localparam poly_t POLY_X4 = poly_t'(40'h01_0000_0000);

  function automatic gf_elem_t gf_mul(input gf_elem_t a, input gf_elem_t b);
    gf_elem_t acc;
    gf_elem_t sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < GF_W; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[GF_W-1] ? ((sh << 1) ^ GF_POLY[GF_W-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  // Zero polynomial reports degree -1 so "deg < t" also covers it.
  function automatic deg_t poly_deg(input poly_t p);
    deg_t d;
    d = -4'sd1;
    for (int i = 0; i <= RS_NSYND; i++) begin
      if (p[i] != '0) d = deg_t'(i);
    end
    return d;
  endfunction
endpackage

// File: rtl/gf256_inv.sv
// Combinational GF(256) inverse as a^254 by square-and-multiply.
// Zero latency; inv(0) returns 0 and is never consumed.
module gf256_inv
  import rs_gf_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [7:0] INV_EXP = 8'd254;

  gf_elem_t acc_c;
  gf_elem_t base_c;

  always_comb begin
    acc_c  = 8'h01;
    base_c = a;
    for (int i = 0; i < GF_W; i++) begin
      if (INV_EXP[i]) acc_c = gf_mul(acc_c, base_c);
      base_c = gf_mul(base_c, base_c);
    end
    y = acc_c;
  end
endmodule

// File: rtl/rs_dec_euclid_alg.sv
// Euclidean key-equation solver: x^4 divided down by S(x) until deg(remainder) < t, yielding Omega(x).
// Result within 16 cycles of sync; a new sync aborts any run and restarts; outputs hold until the next sync.
module rs_dec_euclid_alg
  import rs_gf_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_synd_sync,
  input  logic [7:0] i_s0,
  input  logic [7:0] i_s1,
  input  logic [7:0] i_s2,
  input  logic [7:0] i_s3,
  output logic [7:0] o_gg0,
  output logic [7:0] o_gg1,
  output logic       o_ready
);
  euc_state_t state_q, state_d;
  poly_t      synd_q, a_q, b_q, b_shift, a_step;
  deg_t       deg_s, deg_a, deg_b;
  logic [2:0] shift;
  gf_elem_t   a_lead, b_lead, b_inv, q;
  logic       div_more;
  logic       ld_ab, div_en, swap_en, gg_from_s, gg_from_a;

  assign deg_s = poly_deg(synd_q);
  assign deg_a = poly_deg(a_q);
  assign deg_b = poly_deg(b_q);

  always_comb begin
    a_lead = '0;
    b_lead = '0;
    for (int i = 0; i <= RS_NSYND; i++) begin
      if (deg_a == deg_t'(i)) a_lead = a_q[i];
      if (deg_b == deg_t'(i)) b_lead = b_q[i];
    end
  end

  gf256_inv u_inv (
    .a (b_lead),
    .y (b_inv)
  );

  // One quotient term per cycle; the leading coefficient of A cancels exactly.
  assign q        = gf_mul(a_lead, b_inv);
  assign shift    = 3'(deg_a - deg_b);
  assign div_more = (a_q != '0) && (deg_a >= deg_b);

  always_comb begin
    b_shift = b_q << (GF_W * int'(shift));
    for (int i = 0; i <= RS_NSYND; i++) begin
      a_step[i] = a_q[i] ^ gf_mul(q, b_shift[i]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (i_synd_sync) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: state_d = state_q;
        ST_LOAD: state_d = (deg_s < deg_t'(RS_T)) ? ST_DONE : ST_DIV;
        ST_DIV:  state_d = div_more ? ST_DIV : ST_SWAP;
        ST_SWAP: state_d = (deg_a < deg_t'(RS_T)) ? ST_DONE : ST_DIV;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready   = 1'b0;
    ld_ab     = 1'b0;
    div_en    = 1'b0;
    swap_en   = 1'b0;
    gg_from_s = 1'b0;
    gg_from_a = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ld_ab     = 1'b1;
        gg_from_s = !i_synd_sync && (deg_s < deg_t'(RS_T));
      end
      ST_DIV:  div_en = div_more;
      ST_SWAP: begin
        swap_en   = 1'b1;
        gg_from_a = !i_synd_sync && (deg_a < deg_t'(RS_T));
      end
      ST_DONE: o_ready = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      synd_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      o_gg0  <= '0;
      o_gg1  <= '0;
    end else begin
      if (i_synd_sync) synd_q <= {8'h00, i_s3, i_s2, i_s1, i_s0};
      if (ld_ab) begin
        a_q <= POLY_X4;
        b_q <= synd_q;
      end else if (div_en) begin
        a_q <= a_step;
      end else if (swap_en) begin
        a_q <= b_q;
        b_q <= a_q;
      end
      if (gg_from_s) begin
        o_gg0 <= synd_q[0];
        o_gg1 <= synd_q[1];
      end else if (gg_from_a) begin
        o_gg0 <= a_q[0];
        o_gg1 <= a_q[1];
      end
    end
  end
endmodule

// File: tb/tb_rs_dec_euclid_alg.sv
// Directed and random checks of the key-equation stage against a log/antilog-table Euclid model.
module tb_rs_dec_euclid_alg;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sync = 1'b0;
  logic [7:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  logic [7:0] gg0, gg1;
  logic       ready;

  int n_chk  = 0;
  int n_fail = 0;
  int gexp[256];
  int glog[256];

  always #5 clk = ~clk;

  rs_dec_euclid_alg dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_synd_sync (sync),
    .i_s0        (s0),
    .i_s1        (s1),
    .i_s2        (s2),
    .i_s3        (s3),
    .o_gg0       (gg0),
    .o_gg1       (gg1),
    .o_ready     (ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  function automatic int ginv(input int a);
    return gexp[(255 - glog[a]) % 255];
  endfunction

  function automatic int pdeg(input int p[5]);
    for (int i = 4; i >= 0; i--) if (p[i] != 0) return i;
    return -1;
  endfunction

  // Reference: remainder sequence of x^4 and S(x) until the remainder degree drops below 2.
  task automatic euclid(input int s[5], output int g0, output int g1);
    int a[5], b[5], t[5];
    int da, db, qq;
    a = '{0, 0, 0, 0, 1};
    b = s;
    while (pdeg(b) >= 2) begin
      while (pdeg(a) >= pdeg(b)) begin
        da = pdeg(a);
        db = pdeg(b);
        qq = gmul(a[da], ginv(b[db]));
        for (int i = 0; i <= db; i++) a[i + da - db] = a[i + da - db] ^ gmul(qq, b[i]);
      end
      t = a;
      a = b;
      b = t;
    end
    g0 = b[0];
    g1 = b[1];
  endtask

  task automatic send(input int a, input int b, input int c, input int d);
    s0 = 8'(a); s1 = 8'(b); s2 = 8'(c); s3 = 8'(d);
    sync = 1'b1;
    tick();
    sync = 1'b0;
  endtask

  task automatic run_check(input string tag, input int a, input int b, input int c, input int d,
                           input int e1, input int e0);
    int lat;
    send(a, b, c, d);
    chk({tag, "_busy"}, int'(ready), 0);
    lat = 0;
    while (ready !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency_le16"}, int'(lat <= 16), 1);
    chk({tag, "_gg1"}, int'(gg1), e1);
    chk({tag, "_gg0"}, int'(gg0), e0);
  endtask

  initial begin
    int x, bad, ra, rb, rc, rd, m0, m1;
    int sv[5];
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x;
      glog[x] = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 285;
    end

    tick();
    tick();
    chk("reset_ready", int'(ready), 0);
    chk("reset_gg0", int'(gg0), 0);
    chk("reset_gg1", int'(gg1), 0);
    rst = 1'b0;
    tick();
    chk("idle_ready", int'(ready), 0);

    run_check("c1_alpha", 1, 2, 4, 0, 8'hAD, 8'h00);
    run_check("c2_x3p1", 1, 0, 0, 1, 8'h01, 8'h00);
    run_check("c3_deg0", 1, 0, 0, 0, 8'h00, 8'h01);
    run_check("c4_zero", 0, 0, 0, 0, 8'h00, 8'h00);
    run_check("c5_x3", 0, 0, 0, 1, 8'h00, 8'h00);
    run_check("c2_again", 1, 0, 0, 1, 8'h01, 8'h00);

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (ready !== 1'b1 || gg1 !== 8'h01 || gg0 !== 8'h00) bad++;
    end
    chk("hold_100_cycles", bad, 0);

    send(1, 2, 4, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_ready", int'(ready), 0);
    chk("midrst_gg1", int'(gg1), 0);
    chk("midrst_gg0", int'(gg0), 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("midrst_stays_idle", int'(ready), 0);

    send(1, 2, 4, 0);
    tick();
    tick();
    run_check("abort_restart", 1, 0, 0, 1, 8'h01, 8'h00);

    for (int n = 0; n < 40; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      rb = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      rc = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      rd = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
      sv = '{ra, rb, rc, rd, 0};
      euclid(sv, m0, m1);
      run_check($sformatf("rand%0d", n), ra, rb, rc, rd, m1, m0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
